// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one async-memory request port between INPUTS
// requesters; one transaction in flight, grant held until it completes.
module memory_arbiter #(
  parameter int unsigned INPUTS     = 2,
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [INPUTS-1:0]            io_in_rd,
  input  logic [INPUTS-1:0]            io_in_wr,
  input  logic [INPUTS*ADDR_WIDTH-1:0] io_in_addr,
  input  logic [INPUTS*DATA_WIDTH-1:0] io_in_din,
  output logic [DATA_WIDTH-1:0]        io_in_dout,
  output logic [INPUTS-1:0]            io_in_wait_n,
  output logic [INPUTS-1:0]            io_in_valid,
  output logic                         io_out_rd,
  output logic                         io_out_wr,
  output logic [ADDR_WIDTH-1:0]        io_out_addr,
  output logic [DATA_WIDTH-1:0]        io_out_din,
  input  logic [DATA_WIDTH-1:0]        io_out_dout,
  input  logic                         io_out_wait_n,
  input  logic                         io_out_valid
);

  localparam int unsigned GW     = (INPUTS > 1) ? $clog2(INPUTS) : 1;
  localparam int unsigned NSLOT  = 1 << GW;
  localparam int unsigned AW_PAD = NSLOT * ADDR_WIDTH;
  localparam int unsigned DW_PAD = NSLOT * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    READ_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q,  last_d;

  // Ports padded up to a power of two so grant_q can index without range holes.
  logic [NSLOT-1:0]      rd_pad, wr_pad, req_pad;
  logic [NSLOT-1:0]      wait_pad, valid_pad;
  logic [AW_PAD-1:0]     addr_pad;
  logic [DW_PAD-1:0]     din_pad;
  logic [ADDR_WIDTH-1:0] addr_a [NSLOT];
  logic [DATA_WIDTH-1:0] din_a  [NSLOT];
  logic                  sel_rd, sel_wr;
  logic                  found;
  logic [GW-1:0]         scan;
  logic [GW-1:0]         pick;

  assign io_in_dout = io_out_dout;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(INPUTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    rd_pad   = NSLOT'(io_in_rd);
    wr_pad   = NSLOT'(io_in_wr);
    req_pad  = rd_pad | wr_pad;
    addr_pad = AW_PAD'(io_in_addr);
    din_pad  = DW_PAD'(io_in_din);
    for (int unsigned i = 0; i < NSLOT; i++) begin
      addr_a[i] = addr_pad[i*ADDR_WIDTH +: ADDR_WIDTH];
      din_a[i]  = din_pad[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First requester after the last granted one, wrapping modulo INPUTS.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    scan  = '0;
    for (int unsigned k = 1; k <= INPUTS; k++) begin
      scan = GW'((32'(last_q) + k) % INPUTS);
      if (!found && req_pad[scan]) begin
        found = 1'b1;
        pick  = scan;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    wait_pad    = '0;
    valid_pad   = '0;
    io_out_rd   = 1'b0;
    io_out_wr   = 1'b0;
    io_out_addr = '0;
    io_out_din  = '0;
    sel_rd      = rd_pad[grant_q];
    sel_wr      = wr_pad[grant_q] & ~rd_pad[grant_q];

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        io_out_rd   = sel_rd;
        io_out_wr   = sel_wr;
        io_out_addr = addr_a[grant_q];
        io_out_din  = din_a[grant_q];
        // A requester that withdraws before acceptance gets no strobe.
        wait_pad[grant_q] = io_out_wait_n & (sel_rd | sel_wr);
        if (!(sel_rd | sel_wr)) begin
          state_d = IDLE;
        end else if (io_out_wait_n) begin
          if (sel_rd) begin
            if (io_out_valid) begin
              valid_pad[grant_q] = 1'b1;
              state_d            = IDLE;
            end else begin
              state_d = READ_WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end
      end
      READ_WAIT: begin
        valid_pad[grant_q] = io_out_valid;
        if (io_out_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Strobes and bus are silenced while reset is held; dout still follows memory.
    if (!reset) begin
      wait_pad    = '0;
      valid_pad   = '0;
      io_out_rd   = 1'b0;
      io_out_wr   = 1'b0;
      io_out_addr = '0;
      io_out_din  = '0;
    end

    io_in_wait_n = wait_pad[INPUTS-1:0];
    io_in_valid  = valid_pad[INPUTS-1:0];
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares one asynchronous-memory bus port (rd/wr/addr/din strobes, wait_n accept, valid read-return) between `INPUTS` requesters. It uses round-robin priority and holds each grant until the transaction completes. It sits upstream of the clock-domain data-freezing stage, so that per-client memory paths (CPU, DMA, sprite fetch) can be merged onto one freezer/memory channel. Exactly one transaction is in flight at a time.

## Interface
- `INPUTS`, default 2: number of requester ports (2..8).
- `ADDR_WIDTH`, default 7: address width.
- `DATA_WIDTH`, default 16: data width.
- `clock`, in, 1: sole clock. All logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset. It is sampled on the `clock` edge while low.
- `io_in_rd`, in, INPUTS: per-port read request.
- `io_in_wr`, in, INPUTS: per-port write request.
- `io_in_addr`, in, INPUTS*ADDR_WIDTH: per-port address. Port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `io_in_din`, in, INPUTS*DATA_WIDTH: per-port write data, packed the same way.
- `io_in_dout`, out, DATA_WIDTH: read data, broadcast to all ports. It equals `io_out_dout`.
- `io_in_wait_n`, out, INPUTS: per-port accept strobe.
- `io_in_valid`, out, INPUTS: per-port read-data-valid strobe.
- `io_out_rd`, out, 1: read request to memory.
- `io_out_wr`, out, 1: write request to memory.
- `io_out_addr`, out, ADDR_WIDTH: address to memory.
- `io_out_din`, out, DATA_WIDTH: write data to memory.
- `io_out_dout`, in, DATA_WIDTH: read data from memory.
- `io_out_wait_n`, in, 1: memory accepts the current request.
- `io_out_valid`, in, 1: memory read data is valid.

## Operation
- A requester holds rd or wr, together with addr and din, stable until its `io_in_wait_n` pulses. Asserting rd and wr together is illegal; the arbiter treats it as a read only.
- The state machine has three states: IDLE, BUSY and READ_WAIT.
  - Registers: `grant` (index of the granted port) and `last` (index of the last granted port). Reset sets state=IDLE, `grant`=0 and `last`=INPUTS-1.
- IDLE
  - Requesting ports: req[i] = rd[i] | wr[i].
  - If any port requests, `grant` takes the first requesting index scanning (last+1), (last+2), ... modulo INPUTS. At the same edge, `last` takes that same index and the state goes to BUSY.
  - With no request, the state stays IDLE.
- BUSY
  - The output bus carries the granted port: `io_out_rd` = rd[grant], `io_out_wr` = wr[grant] & ~rd[grant], plus that port's addr and din.
  - `io_in_wait_n[grant]` = `io_out_wait_n`.
  - On an accepted write, the state goes to IDLE.
  - On an accepted read:
    - If `io_out_valid` is also high in the same cycle, `io_in_valid[grant]` pulses and the state goes to IDLE.
    - Otherwise the state goes to READ_WAIT.
  - If the granted port drops both rd and wr before acceptance (a protocol violation), the state goes to IDLE with no strobes.
- READ_WAIT
  - The output rd, wr, addr and din are all 0.
  - `io_in_valid[grant]` = `io_out_valid`. When valid is high, the state goes to IDLE.
  - New requests are ignored, not granted, in this state.
- Outside BUSY, `io_out_rd`, `io_out_wr`, `io_out_addr` and `io_out_din` are all 0.
- Non-granted ports always see wait_n=0 and valid=0.
- Memory inputs (`io_out_wait_n`, `io_out_valid`) are ignored in IDLE.

## Timing
- Reset values: every output is 0 except `io_in_dout`, which follows `io_out_dout`.
- Reset asserted mid-transaction forces IDLE at the next edge and clears all outputs. An in-flight memory read return is then dropped.
- Arbitration latency:
  - A request seen in IDLE at edge k appears on `io_out_*` from cycle k+1.
  - If memory accepts in cycle k+1, the requester's `io_in_wait_n` is high in cycle k+1 (combinational pass-through).
- Between transactions there is at least one IDLE cycle. Back-to-back throughput for zero-wait writes is therefore 1 transaction per 2 cycles.
- wait_n and valid are combinational from the memory inputs while in BUSY or READ_WAIT. They are never registered or stretched.
- Fairness: with all ports requesting continuously, ports are granted in the order 0, 1, ..., INPUTS-1, 0, ... No port waits more than INPUTS-1 transactions.

## Test plan
- Reset: hold reset=0 for 3 cycles with port0 rd=1 → all outputs 0. After release, `io_out_rd`=1 and `io_out_addr`=port0 addr exactly one cycle later.
- Single write: port1 wr=1, addr=0x15, din=0xBEEF; memory wait_n=1 on the first BUSY cycle → `io_out_wr`=1, addr=0x15, din=0xBEEF, `io_in_wait_n`=2'b10 for one cycle. Then IDLE with outputs 0.
- Read with latency: port0 rd, addr=0x03; wait_n after 2 cycles, valid with dout=0x1234 three cycles later → `io_in_valid`=2'b01 for one cycle with `io_in_dout`=0x1234. No strobe reaches port1.
- Same-cycle accept and valid: port0 read; memory wait_n=1, valid=1, dout=0x00FF in the first BUSY cycle → `io_in_wait_n[0]`=1 and `io_in_valid[0]`=1 in that cycle, then IDLE.
- Round-robin: INPUTS=3, all ports issue continuous zero-wait writes → grant sequence 0, 1, 2, 0, 1, 2. Each write spans 2 cycles.
- Violation and mid-read reset:
  - Port1 drops wr while in BUSY → IDLE next cycle with no wait_n.
  - Reset asserted in READ_WAIT → a later `io_out_valid` produces no `io_in_valid`.
